// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// The encodings here are used by the LSU top, its alignment helper and its bus interface.
package mem_lsu_pkg;

  localparam int LSU_XLEN = 32;

  // funct3 size/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Halves must sit on even bytes; words (and unknown sizes) on word boundaries.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus: valid/ready request channel plus a separate response channel.
// The LSU is the master; the memory (or bench) is the slave.
interface mem_lsu_if #(
  parameter int XLEN = mem_lsu_pkg::LSU_XLEN
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_we;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store byte enables and replicated write data,
// load lane extraction with sign/zero extension. Misaligned offsets are rounded down.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [1:0]  off;
  logic [31:0] lane;
  logic        sext;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    off     = offset_i;
    be_o    = BE_WORD;
    wdata_o = store_data_i;
    sext    = ~funct3_i[2];
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = BE_BYTE << off;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        off[0]  = 1'b0;
        be_o    = BE_HALF << off;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: off = 2'b00;
    endcase

    lane = rdata_i >> {off, 3'b000};
    case (funct3_i[1:0])
      2'b00:   load_data_o = {{24{sext & lane[7]}}, lane[7:0]};
      2'b01:   load_data_o = {{16{sext & lane[15]}}, lane[15:0]};
      default: load_data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per instruction and stalls
// the pipeline until it completes. Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN  // byte-lane logic is fixed at 4 lanes; only 32 is supported
) (
  input  logic            clk,
  input  logic            rstn,  // synchronous, active-high despite the name
  input  logic [XLEN-1:0] MEM_result,
  input  logic [XLEN-1:0] MEM_store_data,
  input  logic [2:0]      MEM_funct3,
  input  logic [4:0]      MEM_rd_addr,
  input  logic            MEM_rmem,
  input  logic            MEM_wmem,
  input  logic            MEM_wen_in,
  mem_lsu_if.master       dmem,
  output logic            lsu_stall,
  output logic [XLEN-1:0] MEM_mem_rdata,
  output logic            MEM_wen
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            lsu_misalign,
  output logic [XLEN-1:0] lsu_badaddr
`endif
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [31:0]     load_data;
  logic            is_mem;
  logic            req_ok;
  logic            unused_rd_addr;

  // rd_addr travels to MEM/WB through the pipeline register, not through the LSU.
  assign unused_rd_addr = ^MEM_rd_addr;

  mem_lsu_align u_align (
    .funct3_i     (MEM_funct3),
    .offset_i     (MEM_result[1:0]),
    .store_data_i (MEM_store_data),
    .rdata_i      (rdata_q),
    .be_o         (dmem.dmem_be),
    .wdata_o      (dmem.dmem_wdata),
    .load_data_o  (load_data)
  );

  assign is_mem         = MEM_rmem | MEM_wmem;
  assign dmem.dmem_addr = {MEM_result[XLEN-1:2], 2'b00};
  assign dmem.dmem_we   = MEM_wmem;

`ifdef LSU_MISALIGN_TRAP_EN
  logic            misaligned;
  logic [XLEN-1:0] badaddr_q;

  assign misaligned   = is_mem & is_misaligned(MEM_funct3, MEM_result[1:0]);
  assign req_ok       = is_mem & ~misaligned;
  assign lsu_misalign = misaligned & (state_q == ST_IDLE) & ~rstn;
  assign lsu_badaddr  = lsu_misalign ? MEM_result : badaddr_q;
  assign MEM_wen      = MEM_wen_in & ~lsu_stall & ~lsu_misalign;

  always_ff @(posedge clk) begin
    if (rstn)              badaddr_q <= '0;
    else if (lsu_misalign) badaddr_q <= MEM_result;
  end
`else
  assign req_ok  = is_mem;
  assign MEM_wen = MEM_wen_in & ~lsu_stall;
`endif

  always_comb begin
    state_d             = state_q;
    rdata_d             = rdata_q;
    dmem.dmem_req_valid = 1'b0;
    lsu_stall           = 1'b0;
    MEM_mem_rdata       = '0;
    case (state_q)
      ST_IDLE: begin
        // Responses seen here (late, or in the acceptance cycle) are deliberately dropped.
        if (req_ok) begin
          dmem.dmem_req_valid = 1'b1;
          lsu_stall           = 1'b1;
          if (dmem.dmem_req_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lsu_stall = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          rdata_d = dmem.dmem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Stall drops for exactly this cycle so the pipeline moves past the instruction once.
        MEM_mem_rdata = load_data;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rstn) begin
      dmem.dmem_req_valid = 1'b0;
      lsu_stall           = 1'b0;
      MEM_mem_rdata       = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rstn) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table, multi-cycle corner sequences and
// randomized accesses compared against a byte-level reference model.
module tb_mem_lsu;

  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [31:0] MEM_result, MEM_store_data;
  logic [2:0]  MEM_funct3;
  logic [4:0]  MEM_rd_addr;
  logic        MEM_rmem, MEM_wmem, MEM_wen_in;
  logic        lsu_stall;
  logic [31:0] MEM_mem_rdata;
  logic        MEM_wen;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        lsu_misalign;
  logic [31:0] lsu_badaddr;
`endif

  mem_lsu_if dmem ();

  mem_lsu dut (
    .clk            (clk),
    .rstn           (rstn),
    .MEM_result     (MEM_result),
    .MEM_store_data (MEM_store_data),
    .MEM_funct3     (MEM_funct3),
    .MEM_rd_addr    (MEM_rd_addr),
    .MEM_rmem       (MEM_rmem),
    .MEM_wmem       (MEM_wmem),
    .MEM_wen_in     (MEM_wen_in),
    .dmem           (dmem.master),
    .lsu_stall      (lsu_stall),
    .MEM_mem_rdata  (MEM_mem_rdata),
    .MEM_wen        (MEM_wen)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .lsu_misalign   (lsu_misalign),
    .lsu_badaddr    (lsu_badaddr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [31:0] addr);
    int s = size_of(f3);
    return (int'(addr[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int s = size_of(f3);
    return 4'(((1 << s) - 1) << eff_off(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    int s = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    int s = size_of(f3);
    longint v;
    v = longint'(word >> (8 * eff_off(f3, addr))) & ((longint'(1) << (8 * s)) - 1);
    if (!f3[2] && s < 4 && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
    return 32'(v);
  endfunction

  // ---------------- one complete access, checked every cycle ----------------
  task automatic access(input string tag, input bit load, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] word,
                        input bit wen_in, input int rdy_wait, input int rsp_wait,
                        input bit early_rsp, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int phase = 0;
    int wcyc = 0;
    int stalls = 0;
    int accepts = 0;
    bit done = 0;
    MEM_result     = addr;
    MEM_store_data = sd;
    MEM_funct3     = f3;
    MEM_rd_addr    = 5'($urandom);
    MEM_rmem       = load;
    MEM_wmem       = !load;
    MEM_wen_in     = wen_in;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem.dmem_req_ready = (phase == 0) && (cyc >= rdy_wait);
      dmem.dmem_rsp_valid = ((phase == 1) && (wcyc >= rsp_wait)) || (early_rsp && dmem.dmem_req_ready);
      dmem.dmem_rdata     = (phase == 1) ? word : ~word;
      #1;
      if (!lsu_stall) begin
        done = 1;
      end else begin
        stalls++;
        if (phase == 0) begin
          check1({tag, " req_valid"}, dmem.dmem_req_valid, 1'b1);
          check({tag, " addr"}, dmem.dmem_addr, {addr[31:2], 2'b00});
          check({tag, " be"}, 32'(dmem.dmem_be), 32'(exp_be));
          check1({tag, " we"}, dmem.dmem_we, !load);
          if (!load) check({tag, " wdata"}, dmem.dmem_wdata, exp_wdata);
          if (dmem.dmem_req_valid && dmem.dmem_req_ready) accepts++;
        end else begin
          check1({tag, " wait_valid"}, dmem.dmem_req_valid, 1'b0);
        end
        check1({tag, " stall_wen"}, MEM_wen, 1'b0);
        @(negedge clk);
        if (phase == 1) begin
          if (dmem.dmem_rsp_valid) phase = 2;
          else wcyc++;
        end else if (phase == 0 && dmem.dmem_req_ready) begin
          phase = 1;
        end
      end
    end
    check({tag, " stall_cycles"}, 32'(stalls), 32'(2 + rdy_wait + rsp_wait));
    check({tag, " accepts"}, 32'(accepts), 32'd1);
    check1({tag, " done_valid"}, dmem.dmem_req_valid, 1'b0);
    check1({tag, " done_wen"}, MEM_wen, wen_in);
    if (load) check({tag, " rdata"}, MEM_mem_rdata, exp_load);
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic nonmem(input bit wen_in);
    MEM_rmem            = 1'b0;
    MEM_wmem            = 1'b0;
    MEM_result          = $urandom;
    MEM_wen_in          = wen_in;
    dmem.dmem_req_ready = 1'($urandom);
    dmem.dmem_rsp_valid = 1'($urandom);
    dmem.dmem_rdata     = $urandom;
    #1;
    check1("nonmem stall", lsu_stall, 1'b0);
    check1("nonmem valid", dmem.dmem_req_valid, 1'b0);
    check1("nonmem wen", MEM_wen, wen_in);
    check("nonmem rdata", MEM_mem_rdata, 32'h0);
    dmem.dmem_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    bit          load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] word;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t       vecs[10];
  logic [2:0] f3tab[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"lw_100",  1, T_W,  32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{"lb_103",  1, T_B,  32'h103, 32'h0,        32'h80FFFF7F, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{"lbu_103", 1, T_BU, 32'h103, 32'h0,        32'h80FFFF7F, 4'b1000, 32'h0,        32'h00000080};
    vecs[3] = '{"sh_102",  0, T_H,  32'h102, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0};
    vecs[4] = '{"lh_102",  1, T_H,  32'h102, 32'h0,        32'h80FFFF7F, 4'b1100, 32'h0,        32'hFFFF80FF};
    vecs[5] = '{"lhu_100", 1, T_HU, 32'h100, 32'h0,        32'h80FFFF7F, 4'b0011, 32'h0,        32'h0000FF7F};
    vecs[6] = '{"sb_201",  0, T_B,  32'h201, 32'h000000AB, 32'h0,        4'b0010, 32'hABABABAB, 32'h0};
    vecs[7] = '{"sw_204",  0, T_W,  32'h204, 32'h11223344, 32'h0,        4'b1111, 32'h11223344, 32'h0};
    vecs[8] = '{"lb_pos",  1, T_B,  32'h100, 32'h0,        32'h0000007F, 4'b0001, 32'h0,        32'h0000007F};
    vecs[9] = '{"lh_pos",  1, T_H,  32'h102, 32'h0,        32'h7FFF0000, 4'b1100, 32'h0,        32'h00007FFF};
    f3tab   = '{T_B, T_H, T_W, T_BU, T_HU};

    rstn = 1'b1;
    MEM_result = '0; MEM_store_data = '0; MEM_funct3 = T_W; MEM_rd_addr = '0;
    MEM_rmem = 1'b0; MEM_wmem = 1'b0; MEM_wen_in = 1'b0;
    dmem.dmem_req_ready = 1'b0; dmem.dmem_rsp_valid = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check1("reset valid", dmem.dmem_req_valid, 1'b0);
    check1("reset stall", lsu_stall, 1'b0);
    check("reset rdata", MEM_mem_rdata, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check1("reset misalign", lsu_misalign, 1'b0);
`endif
    @(negedge clk);
    rstn = 1'b0;
    nonmem(1'b1);

    foreach (vecs[i])
      access(vecs[i].name, vecs[i].load, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].word,
             vecs[i].load, 0, 0, 0, vecs[i].be, vecs[i].wdata, vecs[i].ld);

    // Ready held low for three cycles: request must stay stable and be accepted once.
    access("ready_hold", 1, T_W, 32'h300, 32'h0, 32'h0BADF00D, 1, 3, 1, 0,
           4'b1111, 32'h0, 32'h0BADF00D);
    // Response in the acceptance cycle is a protocol error and must be ignored.
    access("early_rsp", 1, T_H, 32'h402, 32'h0, 32'h8001CAFE, 1, 0, 1, 1,
           4'b1100, 32'h0, 32'hFFFF8001);

`ifdef LSU_MISALIGN_TRAP_EN
    MEM_result = 32'h101; MEM_funct3 = T_W; MEM_rmem = 1'b1; MEM_wmem = 1'b0; MEM_wen_in = 1'b1;
    dmem.dmem_req_ready = 1'b1; dmem.dmem_rsp_valid = 1'b0;
    #1;
    check1("misal pulse", lsu_misalign, 1'b1);
    check("misal badaddr", lsu_badaddr, 32'h101);
    check1("misal valid", dmem.dmem_req_valid, 1'b0);
    check1("misal stall", lsu_stall, 1'b0);
    check1("misal wen", MEM_wen, 1'b0);
    @(negedge clk);
    MEM_rmem = 1'b0; MEM_result = 32'h555; dmem.dmem_req_ready = 1'b0;
    #1;
    check1("misal pulse_end", lsu_misalign, 1'b0);
    check("misal badaddr_hold", lsu_badaddr, 32'h101);
    @(negedge clk);
`else
    access("lw_misal", 1, T_W, 32'h101, 32'h0, 32'h89ABCDEF, 1, 0, 0, 0,
           4'b1111, 32'h0, 32'h89ABCDEF);
    access("sh_misal", 0, T_H, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, 0, 0,
           4'b1100, 32'hBEEFBEEF, 32'h0);
`endif

    // Reset while waiting for a response, then a late response arrives in IDLE.
    MEM_result = 32'h100; MEM_funct3 = T_W; MEM_rmem = 1'b1; MEM_wmem = 1'b0; MEM_wen_in = 1'b1;
    dmem.dmem_req_ready = 1'b1;
    #1;
    check1("rstwait issue", lsu_stall, 1'b1);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b0;
    #1;
    check1("rstwait in_wait", lsu_stall, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0; MEM_rmem = 1'b0;
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rdata = 32'hCAFEF00D;
    #1;
    check1("rstwait stall", lsu_stall, 1'b0);
    check1("rstwait valid", dmem.dmem_req_valid, 1'b0);
    check("rstwait rdata", MEM_mem_rdata, 32'h0);
    @(negedge clk);
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    check1("rstwait stall2", lsu_stall, 1'b0);
    check("rstwait rdata2", MEM_mem_rdata, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] a, sd, w;
      ld = 1'($urandom_range(0, 1));
      f3 = f3tab[$urandom_range(0, 4)];
      if (!ld) f3[2] = 1'b0;
      a  = $urandom;
      sd = $urandom;
      w  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1]) a[1:0] = 2'b00;
`endif
      access($sformatf("rand%0d", i), ld, f3, a, sd, w, 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), $urandom_range(0, 2), 0,
             m_be(f3, a), m_wdata(f3, sd), m_load(f3, a, w));
      if ($urandom_range(0, 2) == 0) nonmem(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Issues data-memory requests over a valid/ready request channel with a separate response channel.
- Aligns and sign/zero-extends load data. Generates byte enables and lane-shifted store data.
- Holds the pipeline with a stall request until each access completes, then presents rdata, result, rd_addr, rmem and wen to MEM/WB.

Parameters:
XLEN, 32, data/address width; only 32 is supported (byte-lane logic fixed at 4 lanes).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; synchronous, active-high (asserted = 1) despite the name.
- MEM_result  in  XLEN  ALU result; the effective address for loads/stores.
- MEM_store_data  in  XLEN  rs2 value for stores.
- MEM_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MEM_rd_addr  in  5  destination register.
- MEM_rmem  in  1  load.
- MEM_wmem  in  1  store (never together with MEM_rmem).
- MEM_wen_in  in  1  register write enable from EX/MEM.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  request accepted.
- dmem_addr  out  XLEN  word-aligned address (low 2 bits 0).
- dmem_we  out  1  write request.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_rsp_valid  in  1  response/ack, at least 1 cycle after acceptance.
- dmem_rdata  in  XLEN  raw word read data.
- lsu_stall  out  1  holds PC/IF/ID/EX/EX-MEM, bubbles MEM/WB.
- MEM_mem_rdata  out  XLEN  extended load data to MEM/WB.
- MEM_wen  out  1  register write enable to MEM/WB.

Behaviour:
- States: IDLE, WAIT, DONE. Reset: state=IDLE, rdata_q=0, dmem_req_valid=0, lsu_stall=0, MEM_mem_rdata=0.
- IDLE:
  - If MEM_rmem|MEM_wmem: assert dmem_req_valid and lsu_stall combinationally.
  - On dmem_req_ready, go to WAIT.
  - While ready=0: hold valid high with addr/be/wdata stable; stay in IDLE.
- WAIT:
  - valid=0, lsu_stall=1.
  - On dmem_rsp_valid: capture dmem_rdata into rdata_q, go to DONE.
  - A response arriving in the same cycle as acceptance is a protocol error and is ignored.
- DONE:
  - lsu_stall=0, no request; next cycle IDLE.
  - The pipeline advances exactly once, so the same instruction never reissues.
- Non-memory instruction: no request, lsu_stall=0, pass-through. Zero added latency.
- Minimum load/store latency: 3 cycles (IDLE, WAIT, DONE) with ready=1 and the response one cycle later.
- Byte-enable generation from addr[1:0]:
  - B: be = 0001<<a.
  - H: be = 0011<<a.
  - W: be = 1111.
  - wdata = store_data replicated per lane (byte ×4, half ×2).
- Loads extract lane from rdata_q by addr[1:0]:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: as-is.
- MEM_mem_rdata is valid in DONE only, otherwise 0.
- MEM_wen = MEM_wen_in & ~lsu_stall. No write-back on stall bubbles.
- Misaligned access is H at a[0]=1, or W at a[1:0]≠0; handling depends on the Optional Feature.
- Reset mid-access forces IDLE immediately. A late dmem_rsp_valid arriving in IDLE is ignored.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned access issues no request; lsu_stall=0; MEM_wen=0.
  - Extra output lsu_misalign (1) pulses for that cycle.
  - Extra output lsu_badaddr (XLEN) holds the faulting address for the trap unit.
- Not defined:
  - The address is forced to natural alignment (low bits cleared per size), and the access proceeds normally.
  - No extra ports.

Decomposition:
- defines.v additions:
  - funct3 load/store size encodings.
  - LSU state encodings.
  - Byte-enable constants.
- Sub-module lsu_align: purely combinational. Computes be/wdata lane shifting and load extraction/extension; instantiated once.

Test Plan:
- LW addr 0x100, ready=1, rsp one cycle later with 0xDEADBEEF:
  - stall high exactly 2 cycles.
  - DONE shows MEM_mem_rdata=0xDEADBEEF, MEM_wen=1.
- LB addr 0x103, rdata 0x80FF_FF7F: MEM_mem_rdata=0xFFFFFF80. LBU at the same address: 0x00000080.
- SH addr 0x102, store_data 0x1234ABCD: dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- ready held 0 for 3 cycles: valid stays high with addr/be stable; stall continues; exactly one request accepted.
- Reset asserted in WAIT, then rsp_valid arrives: state=IDLE, stall=0, rdata stays 0.
- LW at 0x101:
  - With macro: lsu_misalign=1, lsu_badaddr=0x101, no request, MEM_wen=0.
  - Without macro: request at 0x100.
